// File: rtl/random_uniform_mc.sv
// random_uniform_mc: multi-channel uniform random source.
// Each channel has its own Fibonacci LFSR. A multiply-shift range map
// converts the LFSR state into a sample in [O_MIN, O_MAX]. A warm-up
// state machine steps every LFSR WARMUP times after reset or reseed,
// then samples flow through a valid/ready handshake. Each LFSR advances
// only when a new sample is loaded.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   seed_load  single-cycle reseed request (wins over a handshake)
//   seed_i     base seed used by seed_load
//   out_ready  consumer ready, shared by all channels
//   out_valid  samples valid
//   uniform_o  channel k at bits [k*OUT_W +: OUT_W]
//   busy       high while warming up
//
// Optional feature, enabled by defining RANDOM_UNIFORM_MC_STATS_EN:
//   sample_cnt  saturating count of completed handshakes
//   range_err   sticky flag for a loaded sample outside [O_MIN, O_MAX]
module random_uniform_mc #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned LFSR_W      = 16,
  parameter int unsigned OUT_W       = 16,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter logic [31:0] SEED_STRIDE = 32'h0000_1F35,
  parameter int unsigned O_MAX       = 1024,
  parameter int unsigned O_MIN       = 1,
  parameter int unsigned WARMUP      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_load,
  input  logic [LFSR_W-1:0]      seed_i,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [N_CH*OUT_W-1:0]  uniform_o,
  output logic                   busy
`ifdef RANDOM_UNIFORM_MC_STATS_EN
  ,
  output logic [31:0]            sample_cnt,
  output logic                   range_err
`endif
);

  localparam int unsigned R  = O_MAX - O_MIN + 1;
  localparam int unsigned RW = $clog2(R + 1);
  localparam int unsigned PW = LFSR_W + RW;

  // Feedback tap masks for the supported widths.
  localparam logic [31:0] TAP32 = (LFSR_W == 16) ? 32'h0000_D008 :
                                  (LFSR_W == 24) ? 32'h00E1_0000 :
                                                   32'h8020_0003;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(TAP32);

  // Elaboration-time parameter checks.
  if (!(LFSR_W == 16 || LFSR_W == 24 || LFSR_W == 32)) begin : g_bad_lfsr_w
    $error("random_uniform_mc: LFSR_W must be 16, 24 or 32");
  end
  if (O_MAX < O_MIN) begin : g_bad_range
    $error("random_uniform_mc: O_MAX must be >= O_MIN");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("random_uniform_mc: N_CH must be 1..16");
  end
  if (WARMUP > 255) begin : g_bad_warmup
    $error("random_uniform_mc: WARMUP must be 0..255");
  end
  if (OUT_W < 32) begin : g_out_w_chk
    if (64'(O_MAX) >= (64'd1 << OUT_W)) begin : g_bad_o_max
      $error("random_uniform_mc: O_MAX does not fit in OUT_W");
    end
  end

  typedef enum logic [0:0] {
    S_WARM = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                        state;
  logic [7:0]                    warm_cnt;
  logic [N_CH-1:0][LFSR_W-1:0]   lfsr;
  logic [N_CH-1:0][LFSR_W-1:0]   lfsr_nxt;
  logic [N_CH-1:0][LFSR_W-1:0]   seed_rst;
  logic [N_CH-1:0][LFSR_W-1:0]   seed_new;
  logic [N_CH*OUT_W-1:0]         mapped;
  logic                          load_c;

  // Per-channel seed; a zero result would lock the LFSR, so it becomes 1.
  function automatic logic [LFSR_W-1:0] seed_of(input logic [LFSR_W-1:0] base,
                                                input int unsigned k);
    logic [63:0] sum;
    sum = 64'(base) + 64'(k) * 64'(SEED_STRIDE);
    seed_of = (sum[LFSR_W-1:0] == '0) ? LFSR_W'(1) : sum[LFSR_W-1:0];
  endfunction

  // One LFSR step; the zero state is forced back to 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    lfsr_step = (s == '0) ? LFSR_W'(1) : {s[LFSR_W-2:0], ^(s & TAPS)};
  endfunction

  // Multiply-shift range map; full-width product, then truncate.
  function automatic logic [OUT_W-1:0] range_map(input logic [LFSR_W-1:0] s);
    logic [PW-1:0] p;
    p = PW'(s) * PW'(R);
    range_map = OUT_W'(p >> LFSR_W) + OUT_W'(O_MIN);
  endfunction

  // Per-channel next state, seeds and mapped samples.
  always_comb begin
    lfsr_nxt = '0;
    seed_rst = '0;
    seed_new = '0;
    mapped   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      lfsr_nxt[k] = lfsr_step(lfsr[k]);
      seed_rst[k] = seed_of(LFSR_W'(SEED), k);
      seed_new[k] = seed_of(seed_i, k);
      mapped[k*OUT_W +: OUT_W] = range_map(lfsr[k]);
    end
  end

  // A sample is loaded on the last warm-up cycle or whenever the output slot frees.
  assign load_c = (state == S_RUN) ? (!out_valid || out_ready)
                                   : (warm_cnt == 8'(WARMUP));

  // Warm-up / run state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= seed_rst;
      state     <= S_WARM;
      warm_cnt  <= '0;
      out_valid <= 1'b0;
      uniform_o <= '0;
      busy      <= 1'b1;
    end else if (seed_load) begin
      lfsr      <= seed_new;
      state     <= S_WARM;
      warm_cnt  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        S_WARM: begin
          lfsr <= lfsr_nxt;
          if (load_c) begin
            uniform_o <= mapped;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_RUN;
          end else begin
            warm_cnt <= warm_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (load_c) begin
            lfsr      <= lfsr_nxt;
            uniform_o <= mapped;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state <= S_WARM;
        end
      endcase
    end
  end

`ifdef RANDOM_UNIFORM_MC_STATS_EN
  logic out_of_range_c;

  // Offset-compare keeps the bound check valid for O_MIN == 0.
  always_comb begin
    out_of_range_c = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if ((32'(mapped[k*OUT_W +: OUT_W]) - O_MIN) > (O_MAX - O_MIN)) begin
        out_of_range_c = 1'b1;
      end
    end
  end

  // Handshake counter and sticky range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      range_err  <= 1'b0;
    end else if (seed_load) begin
      sample_cnt <= '0;
    end else begin
      if (out_valid && out_ready && (sample_cnt != 32'hFFFF_FFFF)) begin
        sample_cnt <= sample_cnt + 32'd1;
      end
      if (load_c && out_of_range_c) begin
        range_err <= 1'b1;
      end
    end
  end
`endif

endmodule
